// File: rtl/uart_transmitter.sv
// Byte FIFO feeding an 8N1 serial transmitter with a per-frame latched bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (line low)
// DATA   | eight data bits, LSB first
// PARITY | even parity over the data byte (UART_TX_PARITY_EN only)
// STOP   | stop bit; last cycle pulses tx_done_o and may chain the next frame
module uart_transmitter #(
  parameter int FifoDepth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [14:0]                  clks_per_bit_i,
  input  logic                         tx_valid_i,
  input  logic [7:0]                   tx_byte_i,
  output logic                         tx_ready_o,
  output logic                         tx_o,
  output logic                         tx_busy_o,
  output logic                         tx_done_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o
);

  localparam int AW = $clog2(FifoDepth);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FifoDepth];
  logic [7:0]    mem_d [FifoDepth];
  logic [7:0]    shift_q, shift_d;
  logic [14:0]   period_q, period_d;
  logic [14:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          load;
  logic          done;
  logic          bit_end;
  logic [14:0]   cnt_next;
  logic [7:0]    head;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(FifoDepth));
  assign empty = (level == '0);
  assign push  = tx_valid_i && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = tx_byte_i;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  assign bit_end  = (cnt_q == period_q - 15'd1);
  assign cnt_next = bit_end ? 15'd0 : cnt_q + 15'd1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      START: begin
        cnt_d = cnt_next;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_next;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          done = 1'b1;
          if (!empty) load = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load chains straight into START, so back-to-back frames have no idle gap.
    if (load) begin
      pop       = 1'b1;
      shift_d   = head;
      period_d  = (clks_per_bit_i == 15'd0) ? 15'd1 : clks_per_bit_i;
      cnt_d     = 15'd0;
      bit_idx_d = 3'd0;
      state_d   = START;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^head;
`endif
    end
  end

  // Line level follows the state being entered so tx_o changes on the same edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      STOP:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= 8'h00;
      shift_q   <= 8'h00;
      period_q  <= 15'd1;
      cnt_q     <= 15'd0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
      shift_q   <= shift_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_o         = tx_q;
  assign tx_ready_o   = !full;
  assign tx_busy_o    = (state_q != IDLE) || !empty;
  assign tx_done_o    = done;
  assign fifo_level_o = level;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized scoreboard bench for uart_transmitter: accepted bytes are queued and
// a line monitor rebuilds each frame from tx_o and compares it to the ideal waveform.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [14:0] clks_per_bit_i = 15'd4;
  logic        tx_valid_i = 1'b0;
  logic [7:0]  tx_byte_i = 8'h00;
  logic        tx_ready_o;
  logic        tx_o;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic [2:0]  fifo_level_o;

  uart_transmitter #(.FifoDepth(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clks_per_bit_i (clks_per_bit_i),
    .tx_valid_i     (tx_valid_i),
    .tx_byte_i      (tx_byte_i),
    .tx_ready_o     (tx_ready_o),
    .tx_o           (tx_o),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o),
    .fifo_level_o   (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int max_level = 0;
  logic [7:0] exp_q[$];
  int done_cycles[$];
  logic cap_s[$];
  logic cap_d[$];

  function automatic void check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endfunction

  // Compare one captured frame against the waveform the spec defines for the oldest queued byte.
  function automatic void check_frame(input int p);
    logic [7:0] b;
    logic [7:0] got;
    logic       eb;
    int         bi;
    int         wbad;
    int         dbad;
    for (int i = 0; i < 8; i++) got[i] = cap_s[(1 + i) * p + p / 2];
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_frame got %02h required no frame", got);
      return;
    end
    b = exp_q.pop_front();
    wbad = 0;
    dbad = 0;
    for (int k = 0; k < NBITS * p; k++) begin
      bi = k / p;
      if (bi == 0)                      eb = 1'b0;
      else if (bi <= 8)                 eb = b[bi-1];
      else if (bi == 9 && NBITS == 11)  eb = ^b;
      else                              eb = 1'b1;
      if (cap_s[k] !== eb) wbad++;
      if (cap_d[k] !== (k == NBITS * p - 1)) dbad++;
    end
    if (wbad != 0) begin
      errors++;
      $display("FAIL frame_wave got %02h (%0d bad samples, period %0d) required %02h", got, wbad, p, b);
    end
    checks++;
    if (dbad != 0) begin
      errors++;
      $display("FAIL done_pulse got %0d misplaced cycles required 0 (byte %02h)", dbad, b);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk_i);
      cyc = cyc + 1;
    end
  end

  // Line monitor and scoreboard feed.
  initial begin
    logic [14:0] cpb_prev;
    logic        cap;
    int          cap_p;
    cpb_prev = 15'd1;
    cap = 1'b0;
    cap_p = 1;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        cap = 1'b0;
        cap_s.delete();
        cap_d.delete();
        exp_q.delete();
      end else begin
        if (tx_valid_i && tx_ready_o) exp_q.push_back(tx_byte_i);
        if (int'(fifo_level_o) > max_level) max_level = int'(fifo_level_o);
        if (!cap && !tx_o) begin
          cap = 1'b1;
          cap_p = (cpb_prev == 15'd0) ? 1 : int'(cpb_prev);
        end
        if (cap) begin
          cap_s.push_back(tx_o);
          cap_d.push_back(tx_done_o);
          if (cap_s.size() == NBITS * cap_p) begin
            check_frame(cap_p);
            cap = 1'b0;
            cap_s.delete();
            cap_d.delete();
          end
        end else if (tx_done_o) begin
          checks++;
          errors++;
          $display("FAIL done_outside_frame got 1 required 0 at cycle %0d", cyc);
        end
        if (tx_done_o) done_cycles.push_back(cyc);
      end
      cpb_prev = clks_per_bit_i;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    tx_valid_i = 1'b1;
    tx_byte_i  = b;
    t = 0;
    while (!tx_ready_o && t < 2000) begin
      tick(1);
      t++;
    end
    if (t >= 2000) check("send_timeout", 1, 0);
    tick(1);
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while ((tx_busy_o || exp_q.size() != 0) && t < bound) begin
      tick(1);
      t++;
    end
    if (t >= bound) check("idle_timeout", 1, 0);
    tick(2);
    check("idle_tx", int'(tx_o), 1);
    check("idle_queue", exp_q.size(), 0);
  endtask

  task automatic check_spacing(input string name, input int n, input int gap);
    check(name, done_cycles.size(), n);
    for (int i = 1; i < done_cycles.size(); i++)
      check(name, done_cycles[i] - done_cycles[i-1], gap);
  endtask

  initial begin
    // Power-on reset.
    tick(5);
    check("rst_tx", int'(tx_o), 1);
    check("rst_ready", int'(tx_ready_o), 1);
    check("rst_busy", int'(tx_busy_o), 0);
    check("rst_done", int'(tx_done_o), 0);
    check("rst_level", int'(fifo_level_o), 0);
    rst_ni = 1'b1;
    tick(2);

    // Single byte, period 4.
    clks_per_bit_i = 15'd4;
    done_cycles.delete();
    send(8'hA5);
    check("single_level", int'(fifo_level_o), 1);
    check("single_busy", int'(tx_busy_o), 1);
    check("single_tx_before_pop", int'(tx_o), 1);
    tick(1);
    check("single_tx_start", int'(tx_o), 0);
    check("single_level_popped", int'(fifo_level_o), 0);
    wait_idle(500);
    check("single_done_count", done_cycles.size(), 1);
    check("single_busy_end", int'(tx_busy_o), 0);

    // Back-to-back at period 2.
    clks_per_bit_i = 15'd2;
    max_level = 0;
    done_cycles.delete();
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    wait_idle(500);
    check("b2b_peak_level", max_level, 2);
    check_spacing("b2b_done_gap", 3, NBITS * 2);

    // Full FIFO at period 8.
    clks_per_bit_i = 15'd8;
    max_level = 0;
    for (int i = 1; i <= 5; i++) send(8'(i));
    check("full_level", int'(fifo_level_o), 4);
    check("full_ready", int'(tx_ready_o), 0);
    send(8'h06);
    wait_idle(2000);
    check("full_peak_level", max_level, 4);

    // Period 0 acts as 1.
    clks_per_bit_i = 15'd0;
    done_cycles.delete();
    send(8'h3A);
    send(8'hC5);
    wait_idle(200);
    check_spacing("p0_done_gap", 2, NBITS);

    // Period change mid-frame only affects the next frame.
    clks_per_bit_i = 15'd4;
    done_cycles.delete();
    send(8'hC3);
    tick(10);
    clks_per_bit_i = 15'd6;
    send(8'h5E);
    wait_idle(500);
    check_spacing("pchg_done_gap", 2, NBITS * 6);

    // Randomized traffic with random periods and gaps.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) clks_per_bit_i = 15'($urandom_range(0, 5));
      send(8'($urandom_range(0, 255)));
      tick($urandom_range(0, 3));
    end
    wait_idle(5000);

    // Mid-frame resets: during data bit 3 of 0x3C (spec case) and during data bit 0 of 0x00.
    for (int r = 0; r < 2; r++) begin
      int t;
      clks_per_bit_i = 15'd4;
      send((r == 0) ? 8'h3C : 8'h00);
      send(8'hE7);
      t = 0;
      while (tx_o && t < 100) begin
        tick(1);
        t++;
      end
      if (t >= 100) check("mrst_start_timeout", 1, 0);
      tick((r == 0) ? 17 : 5);
      check("mrst_level_before", int'(fifo_level_o), 1);
      rst_ni = 1'b0;
      #1;
      check("mrst_tx", int'(tx_o), 1);
      check("mrst_level", int'(fifo_level_o), 0);
      check("mrst_ready", int'(tx_ready_o), 1);
      tick(3);
      rst_ni = 1'b1;
      tick(2);
      check("mrst_busy_after", int'(tx_busy_o), 0);
      done_cycles.delete();
      send(8'h81);
      wait_idle(500);
      check("mrst_done_count", done_cycles.size(), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
